// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and filters kclk/kdata, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and queues decoded entries in a first-word-fall-through FIFO.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 20,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8,
    parameter int DECODE_EN      = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          kclk,
    input  logic                          kdata,
    output logic [7:0]                    out_data,
    output logic                          out_ext,
    output logic                          out_brk,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0] clk_sync, dat_sync;
    logic       clk_filt, dat_filt, clk_filt_d;
    logic [7:0] clk_cnt, dat_cnt;
    logic       fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_filt   <= 1'b1;
            dat_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            clk_cnt    <= 8'd0;
            dat_cnt    <= 8'd0;
        end else begin
            clk_sync   <= {clk_sync[0], kclk};
            dat_sync   <= {dat_sync[0], kdata};
            clk_filt_d <= clk_filt;
            // A line flips only after FILTER_LEN consecutive samples disagree with it.
            if (clk_sync[1] == clk_filt) begin
                clk_cnt <= 8'd0;
            end else if (clk_cnt == 8'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= 8'd0;
            end else begin
                clk_cnt <= clk_cnt + 8'd1;
            end
            if (dat_sync[1] == dat_filt) begin
                dat_cnt <= 8'd0;
            end else if (dat_cnt == 8'(FILTER_LEN - 1)) begin
                dat_filt <= dat_sync[1];
                dat_cnt  <= 8'd0;
            end else begin
                dat_cnt <= dat_cnt + 8'd1;
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;

    state_t        state, state_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          par_bit, par_nx;
    logic [TW-1:0] wd, wd_nx;
    logic          acc_nx, perr_nx, ferr_nx;

    always_comb begin
        state_nx   = state;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        par_nx     = par_bit;
        wd_nx      = wd;
        acc_nx     = 1'b0;
        perr_nx    = 1'b0;
        ferr_nx    = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_filt) begin
                        state_nx   = DATA;
                        bit_idx_nx = 3'd0;
                    end
                end
                DATA: begin
                    shreg_nx   = {dat_filt, shreg[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = PARITY;
                end
                PARITY: begin
                    par_nx   = dat_filt;
                    state_nx = STOP;
                end
                STOP: begin
                    // A bad stop bit outranks a parity fault.
                    if (!dat_filt)             ferr_nx = 1'b1;
                    else if (^{shreg, par_bit}) acc_nx = 1'b1;
                    else                       perr_nx = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
        if (state == IDLE || fall) begin
            wd_nx = '0;
        end else if (wd == TW'(TIMEOUT_CYCLES - 1)) begin
            wd_nx    = '0;
            ferr_nx  = 1'b1;
            state_nx = IDLE;
        end else begin
            wd_nx = wd + TW'(1);
        end
    end

    logic       acc_v;
    logic [7:0] acc_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_idx    <= 3'd0;
            shreg      <= 8'd0;
            par_bit    <= 1'b0;
            wd         <= '0;
            acc_v      <= 1'b0;
            acc_byte   <= 8'd0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_idx    <= bit_idx_nx;
            shreg      <= shreg_nx;
            par_bit    <= par_nx;
            wd         <= wd_nx;
            acc_v      <= acc_nx;
            acc_byte   <= shreg;
            parity_err <= perr_nx;
            frame_err  <= ferr_nx;
        end
    end

    logic       pend_ext, pend_brk, pend_ext_nx, pend_brk_nx;
    logic       push;
    logic [9:0] push_entry;

    always_comb begin
        pend_ext_nx = pend_ext;
        pend_brk_nx = pend_brk;
        push        = 1'b0;
        push_entry  = {pend_brk, pend_ext, acc_byte};
        if (acc_v) begin
            if (DECODE_EN != 0 && acc_byte == 8'hE0) begin
                pend_ext_nx = 1'b1;
            end else if (DECODE_EN != 0 && acc_byte == 8'hF0) begin
                pend_brk_nx = 1'b1;
            end else begin
                push        = 1'b1;
                pend_ext_nx = 1'b0;
                pend_brk_nx = 1'b0;
            end
        end
    end

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ;
    logic          full, pop, wr_en;
    logic [9:0]    head;

    assign full      = (occ == CW'(FIFO_DEPTH));
    assign out_valid = (occ != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~full | pop);
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[7:0] : 8'h00;
    assign out_ext   = out_valid & head[8];
    assign out_brk   = out_valid & head[9];
    assign count     = occ;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            pend_ext <= pend_ext_nx;
            pend_brk <= pend_brk_nx;
            overflow <= push & full & ~pop;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      occ <= occ + CW'(1);
            else if (pop && !wr_en) occ <= occ - CW'(1);
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: three instances (decoded, raw, shallow FIFO) share one PS/2 line;
// a byte-level model predicts entries, error pulses and overflows.
module tb_ps2_scancode_rx;
    localparam int F  = 4;
    localparam int T  = 200;
    localparam int H  = 10;

    logic clk = 1'b0;
    logic rst_n, kclk, kdata;
    logic m_ready, r_ready, d_ready;

    logic [7:0] m_data, r_data, d_data;
    logic       m_ext, m_brk, m_valid, m_perr, m_ferr, m_ovf;
    logic       r_ext, r_brk, r_valid, r_perr, r_ferr, r_ovf;
    logic       d_ext, d_brk, d_valid, d_perr, d_ferr, d_ovf;
    logic [3:0] m_count, r_count;
    logic [2:0] d_count;

    always #5 clk = ~clk;

    ps2_scancode_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(8), .DECODE_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata),
        .out_data(m_data), .out_ext(m_ext), .out_brk(m_brk), .out_valid(m_valid),
        .out_ready(m_ready), .count(m_count), .parity_err(m_perr), .frame_err(m_ferr),
        .overflow(m_ovf));

    ps2_scancode_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(8), .DECODE_EN(0)) dut_raw (
        .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata),
        .out_data(r_data), .out_ext(r_ext), .out_brk(r_brk), .out_valid(r_valid),
        .out_ready(r_ready), .count(r_count), .parity_err(r_perr), .frame_err(r_ferr),
        .overflow(r_ovf));

    ps2_scancode_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(4), .DECODE_EN(1)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata),
        .out_data(d_data), .out_ext(d_ext), .out_brk(d_brk), .out_valid(d_valid),
        .out_ready(d_ready), .count(d_count), .parity_err(d_perr), .frame_err(d_ferr),
        .overflow(d_ovf));

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int m_rise_cyc = 0;
    logic m_valid_q = 1'b0;
    logic [9:0] last_main, last_raw, last_d4;

    logic [9:0] exp_main[$];
    logic [9:0] exp_raw[$];
    logic [9:0] exp_d4[$];
    logic pend_ext = 1'b0;
    logic pend_brk = 1'b0;
    int exp_perr = 0;
    int exp_ferr = 0;
    int exp_ovf = 0;
    int perr_cnt[3];
    int ferr_cnt[3];
    int ovf_cnt[3];
    logic [2:0] perr_q = '0;
    logic [2:0] ferr_q = '0;
    logic [2:0] ovf_q = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input string name, input logic [9:0] act, inout logic [9:0] q[$],
                             output logic [9:0] last);
        last = act;
        if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got entry %0h expected none", name, act);
        end else begin
            check(name, act, q.pop_front());
        end
    endtask

    // Compare process: every accepted pop is matched against the model, every error pulse counted.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid_q = 1'b0;
            perr_q = '0;
            ferr_q = '0;
            ovf_q = '0;
        end else begin
            if (m_valid && !m_valid_q) m_rise_cyc = cyc;
            m_valid_q = m_valid;
            if (m_valid && m_ready) pop_check("main_entry", {m_brk, m_ext, m_data}, exp_main, last_main);
            if (r_valid && r_ready) pop_check("raw_entry", {r_brk, r_ext, r_data}, exp_raw, last_raw);
            if (d_valid && d_ready) pop_check("d4_entry", {d_brk, d_ext, d_data}, exp_d4, last_d4);
            for (int i = 0; i < 3; i++) begin
                logic [2:0] pv, fv, ov;
                pv = {d_perr, r_perr, m_perr};
                fv = {d_ferr, r_ferr, m_ferr};
                ov = {d_ovf, r_ovf, m_ovf};
                if (pv[i]) begin perr_cnt[i]++; check("parity_err_width", 32'(perr_q[i]), 0); end
                if (fv[i]) begin ferr_cnt[i]++; check("frame_err_width", 32'(ferr_q[i]), 0); end
                if (ov[i]) begin ovf_cnt[i]++;  check("overflow_width", 32'(ovf_q[i]), 0); end
            end
            perr_q = {d_perr, r_perr, m_perr};
            ferr_q = {d_ferr, r_ferr, m_ferr};
            ovf_q  = {d_ovf, r_ovf, m_ovf};
        end
    end

    // Byte-level model of what an accepted byte does to each instance.
    task automatic model_accept(input logic [7:0] b);
        logic [9:0] e;
        exp_raw.push_back({2'b00, b});
        if (b == 8'hE0) pend_ext = 1'b1;
        else if (b == 8'hF0) pend_brk = 1'b1;
        else begin
            e = {pend_brk, pend_ext, b};
            exp_main.push_back(e);
            if (!d_ready && exp_d4.size() >= 4) exp_ovf++;
            else exp_d4.push_back(e);
            pend_ext = 1'b0;
            pend_brk = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic b);
        kdata = b;
        repeat (H) @(negedge clk);
        kclk = 1'b0;
        last_fall_cyc = cyc;
        repeat (H) @(negedge clk);
        kclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop_ok);
        logic p;
        p = ~(^b) ^ ~par_ok;
        if (!stop_ok) exp_ferr++;
        else if (!par_ok) exp_perr++;
        else model_accept(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(p);
        drive_bit(stop_ok);
        kdata = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(i[0]);
        kdata = 1'b1;
    endtask

    task automatic check_errs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_perr_count"}, perr_cnt[i], exp_perr);
            check({tag, "_ferr_count"}, ferr_cnt[i], exp_ferr);
        end
        check({tag, "_ovf_main"}, ovf_cnt[0], 0);
        check({tag, "_ovf_d4"}, ovf_cnt[2], exp_ovf);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin perr_cnt[i] = 0; ferr_cnt[i] = 0; ovf_cnt[i] = 0; end
        rst_n = 1'b0; kclk = 1'b1; kdata = 1'b1;
        m_ready = 1'b1; r_ready = 1'b1; d_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_count", m_count, 0);
        check("rst_data", {m_brk, m_ext, m_data}, 0);
        check("rst_pulses", {m_perr, m_ferr, m_ovf}, 0);
        check("rst_d4_count", d_count, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame: entry appears 2 sync + F filter + 2 decode/queue cycles after kclk drops.
        send_frame(8'h1C, 1'b1, 1'b1);
        check("latency", m_rise_cyc - last_fall_cyc, F + 4);
        check("first_entry", last_main, 10'h01C);
        check("raw_first", last_raw, 10'h01C);
        check_errs("single");

        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        check("ext_brk_entry", last_main, 10'h375);
        check("raw_last", last_raw, 10'h075);
        check("main_count_after_pops", m_count, 0);

        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("brk_only", last_main, 10'h25A);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h70, 1'b1, 1'b1);
        check("ext_only", last_main, 10'h170);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        check("zero_byte", last_main, 10'h000);
        check_errs("decode");

        send_frame(8'h1C, 1'b0, 1'b1);
        check("perr_count_zero", m_count, 0);
        send_frame(8'h1C, 1'b1, 1'b0);
        check("ferr_count_zero", m_count, 0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check_errs("faults");

        // Prefixes survive a bad frame and a timeout.
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h33, 1'b0, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        check("ext_survives_perr", last_main, 10'h175);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_partial(5);
        exp_ferr++;
        repeat (T + 3 * H) @(negedge clk);
        check_errs("timeout");
        send_frame(8'h29, 1'b1, 1'b1);
        check("after_timeout", last_main, 10'h229);
        check("raw_after_timeout", last_raw, 10'h029);

        // Glitch one sample shorter than the filter while kdata looks like a start bit.
        kdata = 1'b0;
        repeat (H) @(negedge clk);
        kclk = 1'b0;
        repeat (F - 1) @(negedge clk);
        kclk = 1'b1;
        repeat (H) @(negedge clk);
        kdata = 1'b1;
        repeat (T + H) @(negedge clk);
        check("glitch_count", m_count, 0);
        check_errs("glitch");
        send_frame(8'h4B, 1'b1, 1'b1);
        check("after_glitch", last_main, 10'h04B);

        d_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
        check("d4_full_count", d_count, 4);
        check("d4_model_size", d_count, exp_d4.size());
        check_errs("overflow");
        d_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("d4_last_pop", last_d4, 10'h004);
        check("d4_drained", d_count, 0);

        // Reset with a held entry, a pending E0 and a frame in flight.
        m_ready = 1'b0;
        send_frame(8'h1C, 1'b1, 1'b1);
        check("held_count", m_count, exp_main.size());
        send_frame(8'hE0, 1'b1, 1'b1);
        send_partial(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", m_valid, 0);
        check("async_rst_count", m_count, 0);
        check("async_rst_data", m_data, 0);
        exp_main.delete(); exp_raw.delete(); exp_d4.delete();
        pend_ext = 1'b0; pend_brk = 1'b0;
        repeat (4) @(negedge clk);
        m_ready = 1'b1;
        rst_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        send_frame(8'h1C, 1'b1, 1'b1);
        check("post_reset_entry", last_main, 10'h01C);
        check_errs("reset");

        repeat (10) @(negedge clk);
        check("main_q_empty", exp_main.size(), 0);
        check("raw_q_empty", exp_raw.size(), 0);
        check("d4_q_empty", exp_d4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
